bcd_seq_converter: RTL
======================

// Module: bcd_seq_converter
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-and-add-3) for the 7-seg display path.
//  Converts one BIN_W-bit unsigned value over BIN_W+1 clocks using a start/busy/done handshake.
//  Output register holds the last result between conversions.
//  Sits between the counter/datapath and the SSD digit multiplexer.
// PARAMETERS
//  BIN_W   14  width of binary input, >=1
//  DIGITS  4   number of BCD output digits; bcd width = 4*DIGITS
// PORTS
//  clk    in   1          system clock, all logic on rising edge
//  rst_n  in   1          synchronous, active-low reset
//  start  in   1          request conversion of bin; honoured only when ready
//  bin    in   BIN_W      unsigned value, sampled on the accepted start cycle only
//  ready  out  1          high in IDLE and DONE: a start this cycle is accepted
//  busy   out  1          high while in SHIFT
//  done   out  1          one-cycle pulse; bcd/ovf/blank valid and updated this cycle
//  bcd    out  4*DIGITS   packed BCD result, digit 0 = bcd[3:0] (least significant)
//  ovf    out  1          result did not fit in DIGITS digits; bcd holds low digits
//  blank  out  DIGITS     leading-zero mask, bit k = digit k is a leading zero
// BEHAVIOUR
//  Reset: state=IDLE; ready=1, busy=0, done=0, bcd=0, ovf=0, blank=0; counters/shift regs cleared.
//  Reset is synchronous, wins over all other inputs, and aborts any conversion in flight.
//  FSM IDLE: start=1 -> capture bin into shift reg, clear work BCD reg and ovf flag, cnt=0 -> SHIFT.
//  FSM SHIFT: each cycle, every work digit >=5 gets +3, then {work,shift} shifts left by 1.
//    MSB of bin enters first. cnt increments each cycle; after BIN_W shifts -> DONE.
//  FSM DONE: for one cycle, copy work reg to bcd, copy ovf, compute blank; done=1.
//    start=1 -> capture new bin and go to SHIFT (back-to-back); else -> IDLE.
//  Latency: start accepted at edge N -> done=1 in cycle N+BIN_W+1. Throughput: one result per BIN_W+1 cycles.
//  start during SHIFT is ignored, not queued; bin changes during SHIFT have no effect.
//  ovf: sticky within a conversion. Set if the bit shifted out of the top digit
//    (post add-3 work[4*DIGITS-1]) is 1 on any shift; cleared on accept.
//  bcd, ovf, blank change only on the DONE cycle or on reset; stable otherwise.
//  Digits never exceed 9 when ovf=0. With ovf=1, bcd = value mod 10^DIGITS.
//  BIN_W=1: single SHIFT cycle, latency 2.
// CONFIGURATION
//  BCD_LZ_BLANK_EN defined:
//    blank[k]=1 iff digit k and all higher digits are zero, for k>=1.
//    blank[0] is always 0, so a zero result shows a single "0".
//    blank is registered on the DONE cycle alongside bcd.
//  BCD_LZ_BLANK_EN undefined: blank is tied to all zeros and no blanking logic is built.
// TESTING (defaults BIN_W=14, DIGITS=4 unless stated)
//  bin=9999, start at cycle 0 -> done=1 at cycle 15, bcd=16'h9999, ovf=0; busy high cycles 1-14.
//  bin=0 -> bcd=16'h0000, ovf=0; with BCD_LZ_BLANK_EN, blank=4'b1110.
//  bin=16383 -> bcd=16'h6383, ovf=1. Next conversion, bin=1 -> ovf=0, bcd=16'h0001.
//  Back-to-back: bin=1234, then start held in the DONE cycle with bin=42
//    -> done at 15 (bcd=16'h1234) and at 30 (bcd=16'h0042); blank=4'b1100 with macro.
//  start pulsed again mid-SHIFT with bin=7 -> ignored; result reflects first bin, single done pulse.
//  rst_n=0 at cycle 8 of a conversion -> next cycle IDLE, bcd=0, no done.
//    A new start then converts correctly.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential binary-to-BCD converter (shift-and-add-3).
// One BIN_W-bit value is converted over BIN_W+1 clocks using a start/busy/done handshake.
// The result registers (bcd/ovf/blank) hold the last result between conversions.
// Optional feature macro: BCD_LZ_BLANK_EN builds the registered leading-zero blanking mask.
//
// Handshake: ready=1 (IDLE or DONE) means a start seen on this rising edge is
// accepted and bin is sampled on that same edge. A start while busy is dropped,
// not queued. done is a one-cycle pulse, and bcd/ovf/blank already show the new
// result in that cycle.
module bcd_seq_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  work_q,  work_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ovf_w_q, ovf_w_d;
    logic [BCD_W-1:0]  bcd_q,   bcd_d;
    logic              ovf_q,   ovf_d;

    logic [BCD_W-1:0]  work_adj;
    logic [BCD_W-1:0]  work_shl;
    logic              carry_out;
    logic              last_shift;
    logic              load_res;

    // Add-3 correction on every work digit >= 5, then the combined left shift.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        work_shl   = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
        carry_out  = work_adj[BCD_W-1];
        last_shift = (cnt_q == CNT_W'(BIN_W - 1));
    end

    // Next-state and datapath control; the result registers are loaded on the
    // edge that enters DONE so they are already valid while done is high.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        ovf_w_d  = ovf_w_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        load_res = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    shift_d = bin;
                    work_d  = '0;
                    ovf_w_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_d = shift_q << 1;
                work_d  = work_shl;
                ovf_w_d = ovf_w_q | carry_out;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    state_d  = ST_DONE;
                    bcd_d    = work_shl;
                    ovf_d    = ovf_w_q | carry_out;
                    load_res = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working registers and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            ovf_w_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            ovf_w_q <= ovf_w_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zero_above;

    // Leading-zero mask from the result being loaded; digit 0 is never blanked.
    always_comb begin
        blank_d    = blank_q;
        zero_above = 1'b1;
        if (load_res) begin
            blank_d[0] = 1'b0;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                zero_above = zero_above && (work_shl[4*k +: 4] == 4'd0);
                blank_d[k] = zero_above;
            end
        end
    end

    // Blank mask register, updated alongside bcd.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;

endmodule
